// File: rtl/nba_logic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : nba_logic_pipe
// Description : Two-stage valid/ready logic pipe: (a&b, c^d) combined by mode.
// Revision    : 1.0 - initial release
// ============================================================================
module nba_logic_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] out_cnt
);

    localparam logic [1:0] c_MODE_OR   = 2'b00;
    localparam logic [1:0] c_MODE_AND  = 2'b01;
    localparam logic [1:0] c_MODE_XOR  = 2'b10;
    localparam logic [1:0] c_MODE_NOR  = 2'b11;

    logic             r_v1;
    logic [WIDTH-1:0] r_t1;
    logic [WIDTH-1:0] r_t2;
    logic [1:0]       r_mode;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic [CNT_W-1:0] r_out_cnt;

    logic             w_adv2;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [WIDTH-1:0] w_comb;

    // Stage 2 can take the stage-1 word whenever it is empty or draining.
    assign w_adv2     = r_v1 & (~r_out_valid | out_ready);
    assign in_ready   = ~r_v1 | w_adv2;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    always_comb begin
        w_comb = '0;
        case (r_mode)
            c_MODE_OR:  w_comb = r_t1 | r_t2;
            c_MODE_AND: w_comb = r_t1 & r_t2;
            c_MODE_XOR: w_comb = r_t1 ^ r_t2;
            c_MODE_NOR: w_comb = ~(r_t1 | r_t2);
            default:    w_comb = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_t1   <= '0;
            r_t2   <= '0;
            r_mode <= 2'b00;
        end else if (w_in_xfer) begin
            r_v1   <= 1'b1;
            r_t1   <= a & b;
            r_t2   <= c ^ d;
            r_mode <= mode;
        end else if (w_adv2) begin
            r_v1   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
        end else if (w_adv2) begin
            r_out_valid <= 1'b1;
            r_y         <= w_comb;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_cnt <= '0;
        end else if (w_out_xfer) begin
            r_out_cnt <= r_out_cnt + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign out_cnt   = r_out_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nba_logic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_nba_logic_pipe
// Description : Vector table, corner sequences and random traffic vs. model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nba_logic_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a, b, c, d;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  y;
    logic [15:0] out_cnt;

    logic        in_ready4;
    logic        out_valid4;
    logic [7:0]  y4;
    logic [3:0]  out_cnt4;

    nba_logic_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_cnt(out_cnt)
    );

    nba_logic_pipe #(.WIDTH(8), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .c(c), .d(d), .mode(mode),
        .out_valid(out_valid4), .out_ready(out_ready), .y(y4), .out_cnt(out_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a, b, c, d;
        logic [1:0] mode;
        logic [7:0] exp_y;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    logic [7:0]  q[$];
    logic        m_ov     = 1'b0;
    logic [15:0] m_cnt    = '0;
    logic [7:0]  s_y;
    logic        s_ir;
    logic        s_ov;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_y(input logic [7:0] ia, ib, ic, id, input logic [1:0] im);
        logic [7:0] p, q2;
        p  = ia & ib;
        q2 = ic ^ id;
        case (im)
            2'd0:    return p | q2;
            2'd1:    return p & q2;
            2'd2:    return p ^ q2;
            default: return ~(p | q2);
        endcase
    endfunction

    // One clock: drive, sample mid-cycle, then advance the occupancy model.
    task automatic step(input logic iv, input logic [7:0] ia, ib, ic, id,
                        input logic [1:0] im, input logic ordy);
        logic exp_ir, out_x, in_x, ov_next;
        int   n;
        @(negedge clk);
        in_valid = iv; a = ia; b = ib; c = ic; d = id; mode = im; out_ready = ordy;
        #1;
        n      = q.size();
        exp_ir = (n < 2) || ordy;
        s_y = y; s_ir = in_ready; s_ov = out_valid;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        if (m_ov && n > 0) chk("y", {24'd0, y}, {24'd0, q[0]});
        chk("out_cnt", {16'd0, out_cnt}, {16'd0, m_cnt});
        chk("out_cnt_w4", {28'd0, out_cnt4}, {28'd0, m_cnt[3:0]});
        out_x   = m_ov && ordy;
        in_x    = iv && exp_ir;
        ov_next = (m_ov && !ordy) || (n > int'(m_ov));
        @(posedge clk);
        if (out_x) begin
            void'(q.pop_front());
            m_cnt++;
            n_out++;
        end
        if (in_x) q.push_back(ref_y(ia, ib, ic, id, im));
        m_ov = ov_next;
    endtask

    vec_t tbl[7];
    int   cyc;

    initial begin
        tbl[0] = '{8'hF0, 8'h3C, 8'hAA, 8'h0F, 2'd0, 8'hB5};
        tbl[1] = '{8'hF0, 8'h3C, 8'hAA, 8'h0F, 2'd1, 8'h20};
        tbl[2] = '{8'hF0, 8'h3C, 8'hAA, 8'h0F, 2'd2, 8'h95};
        tbl[3] = '{8'hF0, 8'h3C, 8'hAA, 8'h0F, 2'd3, 8'h4A};
        tbl[4] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 2'd0, 8'hFF};
        tbl[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 2'd3, 8'hFF};
        tbl[6] = '{8'hFF, 8'h0F, 8'hF0, 8'hF0, 2'd2, 8'h0F};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; d = '0; mode = '0;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_y", {24'd0, y}, 32'd0);
        chk("rst_out_cnt", {16'd0, out_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back vectors with out_ready high: y appears two cycles later.
        for (int s = 0; s < 9; s++) begin
            if (s < 7) step(1'b1, tbl[s].a, tbl[s].b, tbl[s].c, tbl[s].d, tbl[s].mode, 1'b1);
            else       step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
            chk("tbl_in_ready", {31'd0, s_ir}, 32'd1);
            if (s >= 2) begin
                chk("tbl_out_valid", {31'd0, s_ov}, 32'd1);
                chk("tbl_y", {24'd0, s_y}, {24'd0, tbl[s-2].exp_y});
            end
        end
        step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
        chk("tbl_out_cnt", {16'd0, out_cnt}, 32'd7);

        // Backpressure: only two sets fit, y holds the first result.
        for (int s = 0; s < 4; s++) begin
            step(1'b1, tbl[s].a, tbl[s].b, tbl[s].c, tbl[s].d, tbl[s].mode, 1'b0);
            if (s >= 2) begin
                chk("bp_in_ready", {31'd0, s_ir}, 32'd0);
                chk("bp_y_hold", {24'd0, s_y}, {24'd0, tbl[0].exp_y});
            end
        end
        step(1'b1, tbl[2].a, tbl[2].b, tbl[2].c, tbl[2].d, tbl[2].mode, 1'b1);
        chk("bp_third_accept", {31'd0, s_ir}, 32'd1);
        step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
        chk("bp_drain1", {24'd0, s_y}, {24'd0, tbl[1].exp_y});
        step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
        chk("bp_drain2", {24'd0, s_y}, {24'd0, tbl[2].exp_y});
        step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);

        // Asynchronous reset mid-cycle with both stages occupied.
        step(1'b1, tbl[4].a, tbl[4].b, tbl[4].c, tbl[4].d, tbl[4].mode, 1'b0);
        step(1'b1, tbl[6].a, tbl[6].b, tbl[6].c, tbl[6].d, tbl[6].mode, 1'b0);
        step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_y", {24'd0, y}, 32'd0);
        chk("arst_out_cnt", {16'd0, out_cnt}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        q.delete();
        m_ov  = 1'b0;
        m_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++)
            step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);

        // Random traffic: 1000 delivered results checked in order by the model.
        n_out = 0;
        cyc   = 0;
        while (n_out < 1000 && cyc < 20000) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
            cyc++;
        end
        chk("random_transfers_done", {31'd0, n_out >= 1000}, 32'd1);
        cyc = 0;
        while (q.size() > 0 && cyc < 10) begin
            step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
            cyc++;
        end
        step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
        chk("final_empty", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nba_logic_pipe.md
NBA_LOGIC_PIPE -- requirements
Module: nba_logic_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, bit width of operands and result.
REQ-002 SHALL provide parameter CNT_W, default 16, width of the delivered-result counter.
REQ-003 SHALL have a single clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream operand set valid.
REQ-007 in_ready  output  1  block can accept an operand set this cycle.
REQ-008 a, b, c, d  input  WIDTH each  operands.
REQ-009 mode  input  2  combine operation, sampled with operands.
REQ-010 out_valid  output  1  y holds a valid result.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 y  output  WIDTH  result.
REQ-013 out_cnt  output  CNT_W  count of completed output transfers.

Function
REQ-014 SHALL accept an operand set on a rising edge where in_valid=1 and in_ready=1 (input transfer).
REQ-015 Stage 1 SHALL register t1=a&b, t2=c^d, mode and valid flag v1 on each input transfer.
REQ-016 Stage 2 SHALL register y from stage 1 by mode: 00 t1|t2, 01 t1&t2, 10 t1^t2, 11 ~(t1|t2), bitwise over WIDTH.
REQ-017 Stage 2 SHALL advance (adv2) when v1=1 and (out_valid=0 or out_ready=1); on adv2, out_valid<=1.
REQ-018 When out_valid=1, out_ready=1 and v1=0, out_valid SHALL clear on that edge.
REQ-019 in_ready SHALL equal (v1=0) or adv2, combinationally.
REQ-020 When no input transfer occurs and stage 1 advances, v1 SHALL clear.
REQ-021 Latency SHALL be 2 cycles from input transfer to out_valid=1 with out_ready held high; throughput one result per cycle.
REQ-022 While out_valid=1 and out_ready=0, y SHALL hold stable; total capacity SHALL be 2 results (stage 1 + stage 2), with no loss or reordering.
REQ-023 Mode SHALL be bound per transaction; mode changes never alter results already accepted.
REQ-024 out_cnt SHALL increment by 1 on each edge with out_valid=1 and out_ready=1, wrapping from 2^CNT_W-1 to 0.
REQ-025 Simultaneous input transfer and output transfer in one cycle SHALL both complete without bubble.
REQ-026 Operands and mode SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-027 On rst_n=0, v1, out_valid, y, t1, t2, stored mode and out_cnt SHALL clear to 0 immediately, independent of clk.
REQ-028 in_ready SHALL be 1 during and after reset; in-flight data is discarded.
REQ-029 First input transfer SHALL occur no earlier than the first rising edge after rst_n deasserts.

Verification (WIDTH=8)
REQ-030 a=F0, b=3C, c=AA, d=0F, mode=00, out_ready=1 -> t1=30, t2=A5, y=B5 with out_valid=1 two cycles after accept; out_cnt=1 one edge later.
REQ-031 Same operands, modes 01/10/11 back-to-back -> y=20, 95, 4A on consecutive cycles; in_ready stays 1.
REQ-032 out_ready=0, push 3 sets continuously -> 2 accepted, in_ready=0 thereafter, y holds first result; raise out_ready -> results drain in order, third set then accepted.
REQ-033 CNT_W=4, 17 output transfers -> out_cnt=1 (wrap verified at 15->0).
REQ-034 Assert rst_n=0 mid-clock with both stages full -> out_valid=0, y=00, out_cnt=0 before next edge; no stale result emerges after release.
REQ-035 Random in_valid/out_ready toggling, 1000 transfers -> outputs match scoreboard of mode-combined (a&b, c^d) in order, no drops or duplicates.
